// File: rtl/nmi_rr_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nmi_arb_pkg : shared types and constants for the nmi arbiters      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package nmi_arb_pkg;

   localparam int          MAX_MST           = 8;
   localparam logic [31:0] TIMEOUT_RDATA_DEF = 32'hDEAD_BEEF;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Index width for a master count, never narrower than one bit.
   function automatic int mst_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nmi_rr_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nmi_rr_arbiter_if : per-master request bus plus native memory side |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface nmi_rr_arbiter_if #(
   parameter int NUM_MST = 2
);
   logic [NUM_MST-1:0][31:0] m_adr_i;
   logic [NUM_MST-1:0][31:0] m_dat_i;
   logic [NUM_MST-1:0][3:0]  m_sel_i;
   logic [NUM_MST-1:0]       m_we_i;
   logic [NUM_MST-1:0]       m_cyc_i;
   logic [NUM_MST-1:0][31:0] m_rdt_o;
   logic [NUM_MST-1:0]       m_ack_o;
   logic [NUM_MST-1:0]       m_err_o;
   logic                     nmi_valid_o;
   logic [31:0]              nmi_addr_o;
   logic [31:0]              nmi_wdata_o;
   logic [3:0]               nmi_wstrb_o;
   logic [31:0]              nmi_rdata_i;
   logic                     nmi_ready_i;

   modport slave (
      input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, nmi_rdata_i, nmi_ready_i,
      output m_rdt_o, m_ack_o, m_err_o, nmi_valid_o, nmi_addr_o, nmi_wdata_o, nmi_wstrb_o
   );

   modport master (
      output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, nmi_rdata_i, nmi_ready_i,
      input  m_rdt_o, m_ack_o, m_err_o, nmi_valid_o, nmi_addr_o, nmi_wdata_o, nmi_wstrb_o
   );
endinterface
`default_nettype wire

// File: rtl/nmi_rr_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pick : combinational round-robin selector, search from ptr+1    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] gnt_o,
   output logic             vld_o
);
   logic [IDX_W-1:0] cand;

   // Walk from farthest to nearest so the nearest requester after ptr wins.
   always_comb begin
      gnt_o = '0;
      vld_o = 1'b0;
      cand  = '0;
      for (int k = N; k >= 1; k--) begin
         cand = IDX_W'((int'(ptr_i) + k) % N);
         if (req_i[cand]) begin
            gnt_o = cand;
            vld_o = 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/nmi_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nmi_rr_arbiter : N-master round-robin arbiter onto one nmi port    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module nmi_rr_arbiter
   import nmi_arb_pkg::*;
#(
   parameter int          NUM_MST       = 2,
   parameter int          TIMEOUT_CYC   = 0,
   parameter logic [31:0] TIMEOUT_RDATA = TIMEOUT_RDATA_DEF
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   nmi_rr_arbiter_if.slave    bus
);
   localparam int IDX_W = mst_idx_w(NUM_MST);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_vld;
   logic             busy;
   logic             tmo_hit;
   logic             done;

   rr_pick #(
      .N     (NUM_MST),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i (bus.m_cyc_i),
      .ptr_i (ptr_q),
      .gnt_o (pick_idx),
      .vld_o (pick_vld)
   );

   assign busy = (state_q == BUSY);
   assign done = busy && (bus.nmi_ready_i || tmo_hit);

   generate
      if (TIMEOUT_CYC > 0) begin : g_tmo
         localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
         logic [TMO_W-1:0] tmo_q, tmo_d;

         // Ready has priority, so expiry only counts when the slave stays silent.
         assign tmo_hit = busy && !bus.nmi_ready_i && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

         always_comb begin
            tmo_d = '0;
            if (busy && !done) begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               tmo_q <= '0;
            end else begin
               tmo_q <= tmo_d;
            end
         end
      end else begin : g_no_tmo
         assign tmo_hit = 1'b0;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               gnt_d   = pick_idx;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (done) begin
               ptr_d   = gnt_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= IDX_W'(NUM_MST - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      bus.nmi_valid_o = busy;
      bus.nmi_addr_o  = '0;
      bus.nmi_wdata_o = '0;
      bus.nmi_wstrb_o = '0;
      bus.m_ack_o     = '0;
      bus.m_err_o     = '0;
      if (busy) begin
         bus.nmi_addr_o  = bus.m_adr_i[gnt_q];
         bus.nmi_wdata_o = bus.m_dat_i[gnt_q];
         bus.nmi_wstrb_o = bus.m_we_i[gnt_q] ? bus.m_sel_i[gnt_q] : 4'b0000;
      end
      if (done) begin
         bus.m_ack_o[gnt_q] = 1'b1;
         bus.m_err_o[gnt_q] = tmo_hit;
      end
      for (int i = 0; i < NUM_MST; i++) begin
         bus.m_rdt_o[i] = tmo_hit ? TIMEOUT_RDATA : bus.nmi_rdata_i;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_nmi_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_nmi_rr_arbiter : scoreboard bench for nmi_rr_arbiter            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_nmi_rr_arbiter;
   localparam int NM = 4;

   typedef struct {
      int          idx;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        man_rdy = 1'b0;
   logic [31:0] man_rdata = '0;
   logic        auto_slave = 1'b0;
   logic        auto_plan = 1'b0;
   logic        auto_rdy = 1'b0;

   exp_t exp_q[$];
   int   ack_cyc[$];
   int   cyc_no = 0;
   int   n_ack  = 0;
   int   total  = 0;
   int   bad    = 0;

   nmi_rr_arbiter_if #(.NUM_MST(NM)) bus ();

   nmi_rr_arbiter #(
      .NUM_MST     (NM),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_no++;

   // Slave model: manual control, or a registered zero-wait memory.
   assign bus.nmi_ready_i = auto_slave ? auto_rdy : man_rdy;
   assign bus.nmi_rdata_i = auto_slave ? (bus.nmi_addr_o ^ 32'hFFFF_0000) : man_rdata;

   always @(negedge clk) auto_plan = bus.nmi_valid_o && !bus.nmi_ready_i;
   always @(posedge clk) begin
      #1;
      auto_rdy = auto_slave && auto_plan;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc_no);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus.m_ack_o !== '0 || bus.m_err_o !== '0) begin
         ack_cyc.push_back(cyc_no);
         n_ack++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: ack=%b err=%b expected none", bus.m_ack_o, bus.m_err_o);
         end else begin
            e = exp_q.pop_front();
            chk("ack_vec", 32'(bus.m_ack_o), 32'(1 << e.idx));
            chk("err_vec", 32'(bus.m_err_o), e.err ? 32'(1 << e.idx) : 32'h0);
            chk("ack_rdata", bus.m_rdt_o[e.idx], e.rdata);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input int idx, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel);
      bus.m_we_i[idx]  = we;
      bus.m_adr_i[idx] = adr;
      bus.m_dat_i[idx] = dat;
      bus.m_sel_i[idx] = sel;
   endtask

   task automatic chk_bus(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
      @(negedge clk);
      chk("nmi_valid", 32'(bus.nmi_valid_o), 32'h1);
      chk("nmi_addr", bus.nmi_addr_o, adr);
      chk("nmi_wdata", bus.nmi_wdata_o, dat);
      chk("nmi_wstrb", 32'(bus.nmi_wstrb_o), we ? 32'(sel) : 32'h0);
   endtask

   task automatic chk_quiet(input string tag);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(bus.nmi_valid_o), 32'h0);
      chk({tag, "_ack"}, 32'(bus.m_ack_o), 32'h0);
      chk({tag, "_err"}, 32'(bus.m_err_o), 32'h0);
      chk({tag, "_wstrb"}, 32'(bus.nmi_wstrb_o), 32'h0);
      chk({tag, "_addr"}, bus.nmi_addr_o, 32'h0);
      chk({tag, "_wdata"}, bus.nmi_wdata_o, 32'h0);
   endtask

   task automatic do_xfer(input int idx, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input int nwait, input logic [31:0] rdata);
      step();
      set_m(idx, we, adr, dat, sel);
      bus.m_cyc_i[idx] = 1'b1;
      exp_q.push_back('{idx, 1'b0, rdata});
      @(negedge clk);
      chk("valid_before_grant", 32'(bus.nmi_valid_o), 32'h0);
      step();
      repeat (nwait) begin
         chk_bus(we, adr, dat, sel);
         step();
      end
      man_rdy   = 1'b1;
      man_rdata = rdata;
      chk_bus(we, adr, dat, sel);
      step();
      man_rdy          = 1'b0;
      bus.m_cyc_i[idx] = 1'b0;
      @(negedge clk);
      chk("bubble_valid", 32'(bus.nmi_valid_o), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int v_cyc;
      int base;
      bus.m_adr_i = '0;
      bus.m_dat_i = '0;
      bus.m_sel_i = '0;
      bus.m_we_i  = '0;
      bus.m_cyc_i = '0;

      // Reset holds everything quiet even with a request and ready present.
      bus.m_cyc_i[0] = 1'b1;
      man_rdy = 1'b1;
      repeat (2) @(negedge clk);
      chk_quiet("reset");
      step();
      bus.m_cyc_i[0] = 1'b0;
      man_rdy = 1'b0;
      step();
      rst_n = 1'b1;

      // Read with two wait states, then a write and a read from master 1.
      do_xfer(0, 1'b0, 32'h3000_0000, 32'h0, 4'hF, 2, 32'h1234_5678);
      do_xfer(1, 1'b1, 32'h0300_0004, 32'hAABB_CCDD, 4'b0011, 0, 32'h0000_0000);
      do_xfer(1, 1'b0, 32'h0300_0008, 32'h0, 4'hF, 1, 32'h5555_AAAA);

      // Timeout on master 2, then master 3 sees ready on its expiry cycle.
      step();
      set_m(2, 1'b0, 32'h2000_0000, 32'h0, 4'hF);
      set_m(3, 1'b0, 32'h2000_0100, 32'h0, 4'hF);
      bus.m_cyc_i[2] = 1'b1;
      bus.m_cyc_i[3] = 1'b1;
      exp_q.push_back('{2, 1'b1, 32'hDEAD_BEEF});
      exp_q.push_back('{3, 1'b0, 32'h0BAD_F00D});
      step();
      chk_bus(1'b0, 32'h2000_0000, 32'h0, 4'hF);
      v_cyc = cyc_no;
      repeat (15) step();
      step();
      bus.m_cyc_i[2] = 1'b0;
      chk("tmo_latency", 32'(ack_cyc[$] - v_cyc + 1), 32'd16);
      @(negedge clk);
      chk("tmo_valid_drop", 32'(bus.nmi_valid_o), 32'h0);
      step();
      chk_bus(1'b0, 32'h2000_0100, 32'h0, 4'hF);
      repeat (15) step();
      man_rdy   = 1'b1;
      man_rdata = 32'h0BAD_F00D;
      step();
      man_rdy        = 1'b0;
      bus.m_cyc_i[3] = 1'b0;
      @(negedge clk);
      chk("after_tie_valid", 32'(bus.nmi_valid_o), 32'h0);

      // Reset mid-transfer with stale ready, then master 0 wins first.
      do_xfer(0, 1'b0, 32'h4000_0000, 32'h0, 4'hF, 0, 32'h4444_0000);
      step();
      set_m(2, 1'b0, 32'h2000_0200, 32'h0, 4'hF);
      bus.m_cyc_i[2] = 1'b1;
      step();
      chk_bus(1'b0, 32'h2000_0200, 32'h0, 4'hF);
      step();
      rst_n   = 1'b0;
      man_rdy = 1'b1;
      chk_quiet("midrst");
      step();
      bus.m_cyc_i[2] = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      step();
      man_rdy = 1'b0;
      step();
      set_m(0, 1'b0, 32'h5000_0000, 32'h0, 4'hF);
      set_m(1, 1'b0, 32'h5000_0010, 32'h0, 4'hF);
      bus.m_cyc_i[1:0] = 2'b11;
      exp_q.push_back('{0, 1'b0, 32'h6000_0000});
      exp_q.push_back('{1, 1'b0, 32'h6000_0010});
      step();
      man_rdy   = 1'b1;
      man_rdata = 32'h6000_0000;
      chk_bus(1'b0, 32'h5000_0000, 32'h0, 4'hF);
      step();
      man_rdy        = 1'b0;
      bus.m_cyc_i[0] = 1'b0;
      step();
      man_rdy   = 1'b1;
      man_rdata = 32'h6000_0010;
      chk_bus(1'b0, 32'h5000_0010, 32'h0, 4'hF);
      step();
      man_rdy        = 1'b0;
      bus.m_cyc_i[1] = 1'b0;

      // All masters hold requests against a zero-wait slave; last winner was 1.
      step();
      step();
      auto_slave = 1'b1;
      for (int i = 0; i < NM; i++) set_m(i, 1'b0, 32'h1000_0000 + 32'(i * 16), 32'h0, 4'hF);
      for (int k = 0; k < 8; k++) begin
         int m;
         m = (2 + k) % NM;
         exp_q.push_back('{m, 1'b0, (32'h1000_0000 + 32'(m * 16)) ^ 32'hFFFF_0000});
      end
      base = ack_cyc.size();
      bus.m_cyc_i = '1;
      begin
         int t;
         for (t = 0; t < 200; t++) begin
            step();
            if (ack_cyc.size() >= base + 8) break;
         end
         bus.m_cyc_i = '0;
         chk("rr_acks_seen", 32'(t < 200), 32'h1);
      end
      step();
      auto_slave = 1'b0;
      for (int k = 1; k < 8; k++) begin
         if (base + k < ack_cyc.size())
            chk("rr_ack_spacing", 32'(ack_cyc[base + k] - ack_cyc[base + k - 1]), 32'd3);
      end

      repeat (3) step();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/nmi_rr_arbiter.md
Name: nmi_rr_arbiter

Overview:
- Parametrised N-master arbiter. Concentrates NUM_MST Wishbone-style request ports (core ibus/dbus, DMA, debug) onto one native memory interface (nmi).
- Round-robin fairness, registered grant, optional bus-hang timeout with error ack.
- Sits between user cores and the SoC interconnect. Generalises the two-port I/D arbiter to any master count, and drops its "never simultaneous" assumption.

Parameters:
- NUM_MST, 2, number of masters (2..8); index 0 is the lowest-index master.
- TIMEOUT_CYC, 0, cycles in BUSY before forced error ack; 0 disables the timeout logic entirely.
- TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on a timed-out access.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset
- m_adr_i  in  NUM_MST x 32  per-master byte address
- m_dat_i  in  NUM_MST x 32  per-master write data
- m_sel_i  in  NUM_MST x 4  per-master byte select
- m_we_i  in  NUM_MST  per-master write enable
- m_cyc_i  in  NUM_MST  per-master request; held until ack
- m_rdt_o  out  NUM_MST x 32  read data, shared broadcast of nmi_rdata_i or TIMEOUT_RDATA
- m_ack_o  out  NUM_MST  one-cycle acknowledge to the granted master only
- m_err_o  out  NUM_MST  qualifies m_ack_o as a timeout
- nmi_valid_o  out  1  request valid
- nmi_addr_o  out  32  granted address
- nmi_wdata_o  out  32  granted write data
- nmi_wstrb_o  out  4  granted sel when we=1, else 4'b0
- nmi_rdata_i  in  32  read data
- nmi_ready_i  in  1  transfer complete

Interface: one clock, clk_i. Reset rst_n_i is asynchronous, active-low.

Behaviour:
- State machine: IDLE, BUSY. Registers: state, grant index gnt_q, rr pointer ptr_q, timeout counter tmo_q.
- Reset values: state=IDLE, gnt_q=0, ptr_q=NUM_MST-1 (master 0 wins first), tmo_q=0. All outputs 0: nmi_valid_o, m_ack_o, m_err_o, nmi_wstrb_o, address/data.
- IDLE, any m_cyc_i high: pick the first requester searching ptr_q+1, ptr_q+2, … modulo NUM_MST. Register it into gnt_q and go to BUSY. No request means stay in IDLE.
- BUSY:
  - nmi_valid_o=1.
  - nmi_addr_o, nmi_wdata_o and nmi_wstrb_o are muxed combinationally from master gnt_q.
  - tmo_q increments every cycle.
- Latency: request seen in cycle 0 gives nmi_valid_o in cycle 1.
- BUSY with nmi_ready_i=1:
  - m_ack_o[gnt_q]=1 in the same cycle, with m_rdt_o = nmi_rdata_i.
  - ptr_q<=gnt_q, tmo_q<=0, go to IDLE.
- Mandatory IDLE bubble after each ack lets the master drop m_cyc_i. Back-to-back throughput is one transfer per 3 cycles with zero-wait ready.
- Timeout (TIMEOUT_CYC>0, BUSY, tmo_q==TIMEOUT_CYC-1, no ready):
  - m_ack_o[gnt_q]=1, m_err_o[gnt_q]=1, m_rdt_o=TIMEOUT_RDATA.
  - nmi_valid_o drops next cycle; ptr_q<=gnt_q, go to IDLE.
- Ready and timeout in the same cycle: ready wins, err=0.
- nmi_ready_i while IDLE is ignored, so no ack is generated.
- m_cyc_i of the granted master dropping while BUSY is a master protocol violation. nmi_valid_o stays high until ready or timeout, and the resulting ack is still pulsed.
- Grant never changes while BUSY, whatever other requests arrive.
- Reset asserted mid-transfer: immediate return to IDLE with outputs 0; in-flight access is abandoned.
- m_ack_o and m_err_o are never high for non-granted masters. Never more than one ack bit is high.

Decomposition:
- Shared package nmi_arb_pkg holds:
  - localparam MST_IDX_W = $clog2(NUM_MST) (min 1).
  - typedef arb_state_e {IDLE, BUSY}.
  - TIMEOUT_RDATA default constant.
- Sub-module rr_pick: purely combinational round-robin selector. Inputs are req vector and ptr; outputs are gnt index and valid. It is reused by other arbiters in the SoC.

Test Plan:
- NUM_MST=2, m0 reads 0x3000_0000 with ready 2 cycles after valid, rdata 0x1234_5678 -> nmi_valid_o asserts cycle 1, m_ack_o[0] pulses with m_rdt_o=0x1234_5678, m_err_o=0.
- m1 writes 0x0300_0004, sel=4'b0011, data 0xAABB_CCDD -> nmi_wstrb_o=4'b0011, nmi_wdata_o=0xAABB_CCDD. A read from the same master gives nmi_wstrb_o=0.
- NUM_MST=4, all four hold m_cyc_i continuously with zero-wait ready -> grant order 0,1,2,3,0,…; each ack separated by exactly 3 cycles.
- TIMEOUT_CYC=16, nmi_ready_i tied 0 -> ack+err to the granted master 16 cycles after valid, m_rdt_o=0xDEAD_BEEF, next master granted after the bubble.
- Ready arrives on the same cycle as timeout expiry -> err=0, rdata from nmi_rdata_i.
- rst_n_i pulled low in BUSY, released -> all outputs 0 during reset, master 0 granted first after release, stale ready ignored.
